// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and helpers for the clkgen_div clock generator.
// Holds the divide/phase clamp rules, the reconfiguration FSM states and
// the lock counter width.
package clkgen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } rcfg_state_t;

    // Wide enough for any practical LOCK_CYCLES value.
    localparam int LOCK_W = 16;

    // A divider below 2 cannot produce a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

    // The counter never reaches div, so the phase is limited to div-1.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div);
        return (phase >= div) ? (div - 32'd1) : phase;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one divider channel. Counts 0..div-1 and produces a
// registered divided clock level plus a one-cycle tick at each wrap.
// An apply strobe swaps in a new ratio and phase exactly at the wrap.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int                CNT_W     = 8,
    parameter logic [CNT_W-1:0]  DIV_RST   = 8'd4,
    parameter logic [CNT_W-1:0]  PHASE_RST = 8'd3
) (
    input  logic             refclk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             apply,
    input  logic [CNT_W-1:0] new_div,
    input  logic [CNT_W-1:0] new_phase,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    assign wrap = (cnt == div - 1'b1);

    // Counter, active ratio and registered outputs; frozen until release.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= PHASE_RST;
            div     <= DIV_RST;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (run) begin
            clk_out <= (cnt < (div >> 1));
            tick    <= wrap;
            if (apply) begin
                div <= new_div;
                cnt <= new_phase;
            end else if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkgen_div.sv
// clkgen_div: NUM_CH divided clocks and ticks derived from refclk, with a
// lock indicator. Runtime reload of ratio/phase (shadow registers plus an
// IDLE/PEND FSM) is built only when CLKGEN_DYN_RECONFIG_EN is defined;
// otherwise ratios are fixed at DIV_INIT/PHASE_INIT.
module clkgen_div
    import clkgen_pkg::*;
#(
    parameter int                        NUM_CH      = 2,
    parameter int                        CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT    = {8'd125, 8'd4},
    parameter logic [NUM_CH*CNT_W-1:0]   PHASE_INIT  = {8'd124, 8'd3},
    parameter int                        LOCK_CYCLES = 16,
    localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              load_reg,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_div,
    input  logic [CNT_W-1:0]  load_phase,
    output logic              busy,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

    logic [1:0]        sync;
    logic              run;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic [CNT_W-1:0]  new_div;
    logic [CNT_W-1:0]  new_phase;
    logic [LOCK_W-1:0] lock_cnt;

    // Two-flop release synchronizer; counters run once sync[1] is high.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign run = sync[1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] DIV_RST =
            CNT_W'(clamp_div(32'(DIV_INIT[i*CNT_W +: CNT_W])));
        localparam logic [CNT_W-1:0] PH_RST =
            CNT_W'(clamp_phase(32'(PHASE_INIT[i*CNT_W +: CNT_W]), 32'(DIV_RST)));

        clkgen_channel #(
            .CNT_W     (CNT_W),
            .DIV_RST   (DIV_RST),
            .PHASE_RST (PH_RST)
        ) u_ch (
            .refclk    (refclk),
            .reset_n   (reset_n),
            .run       (run),
            .apply     (apply[i]),
            .new_div   (new_div),
            .new_phase (new_phase),
            .wrap      (wrap[i]),
            .clk_out   (clk_out[i]),
            .tick      (tick[i])
        );
    end

`ifdef CLKGEN_DYN_RECONFIG_EN
    localparam logic [CNT_W-1:0] SH_DIV_RST =
        CNT_W'(clamp_div(32'(DIV_INIT[CNT_W-1:0])));
    localparam logic [CNT_W-1:0] SH_PH_RST =
        CNT_W'(clamp_phase(32'(PHASE_INIT[CNT_W-1:0]), 32'(SH_DIV_RST)));

    rcfg_state_t      state_q, state_d;
    logic             capture;
    logic             ch_ok;
    logic             tgt_wrap;
    logic [CH_W-1:0]  sh_ch;
    logic [CNT_W-1:0] sh_div;
    logic [CNT_W-1:0] sh_phase;
    logic [CNT_W-1:0] cap_div;
    logic [CNT_W-1:0] cap_phase;

    assign cap_div   = CNT_W'(clamp_div(32'(load_div)));
    assign cap_phase = CNT_W'(clamp_phase(32'(load_phase), 32'(cap_div)));
    assign ch_ok     = (32'(load_ch) < NUM_CH);
    assign tgt_wrap  = wrap[sh_ch];

    // Reconfiguration FSM state register.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture a valid request when idle; release once the target channel wraps.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && load_reg && ch_ok) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (run && tgt_wrap) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Shadow copy of the pending request, already clamped.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            sh_ch    <= '0;
            sh_div   <= SH_DIV_RST;
            sh_phase <= SH_PH_RST;
        end else if (capture) begin
            sh_ch    <= load_ch;
            sh_div   <= cap_div;
            sh_phase <= cap_phase;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_apply
        assign apply[i] = (state_q == PEND) && run && wrap[i] && (sh_ch == CH_W'(i));
    end

    assign busy      = (state_q == PEND);
    assign new_div   = sh_div;
    assign new_phase = sh_phase;
`else
    logic unused_load;

    assign unused_load = ^{load_reg, load_ch, load_div, load_phase, wrap};
    assign apply       = '0;
    assign busy        = 1'b0;
    assign new_div     = '0;
    assign new_phase   = '0;
`endif

    // Lock counter: restarts at release and at every apply, saturates at LOCK_CYCLES.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
        end else if (run) begin
            if (|apply) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    assign locked = (lock_cnt == LOCK_MAX) && !busy;

endmodule

// File: tb/tb_clkgen_div.sv
// tb_clkgen_div: randomized self-checking bench for clkgen_div. The
// reference model tracks each channel as (ratio, phase origin, cycles since
// origin) and derives the counter position with modulo arithmetic.
// Works for both builds; with CLKGEN_DYN_RECONFIG_EN undefined the model
// ignores load requests.
module tb_clkgen_div;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int LOCK_CYCLES = 16;
`ifdef CLKGEN_DYN_RECONFIG_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    logic              refclk     = 1'b0;
    logic              reset_n    = 1'b0;
    logic              load_reg   = 1'b0;
    logic [0:0]        load_ch    = '0;
    logic [CNT_W-1:0]  load_div   = '0;
    logic [CNT_W-1:0]  load_phase = '0;
    logic              busy;
    logic              locked;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int init_div[NUM_CH] = '{4, 125};
    int init_ph[NUM_CH]  = '{3, 124};
    int m_div[NUM_CH];
    int m_ph0[NUM_CH];
    int m_k[NUM_CH];
    int rel;
    int lock_age;
    bit pend;
    int p_ch, p_div, p_ph;
    logic [NUM_CH-1:0] e_clk, e_tick;

    clkgen_div dut (
        .refclk     (refclk),
        .reset_n    (reset_n),
        .load_reg   (load_reg),
        .load_ch    (load_ch),
        .load_div   (load_div),
        .load_phase (load_phase),
        .busy       (busy),
        .clk_out    (clk_out),
        .tick       (tick),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    function automatic int clampd(int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int clampp(int p, int d);
        return (p >= d) ? d - 1 : p;
    endfunction

    function automatic logic [5:0] expv();
        logic lk;
        lk = (lock_age >= LOCK_CYCLES) && !pend;
        return {e_clk, e_tick, pend, lk};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c] = clampd(init_div[c]);
            m_ph0[c] = clampp(init_ph[c], m_div[c]);
            m_k[c]   = 0;
        end
        rel = 0; lock_age = 0; pend = 0;
        p_ch = 0; p_div = 0; p_ph = 0;
        e_clk = '0; e_tick = '0;
    endtask

    // One rising edge: advance the model with the inputs seen at that edge.
    task automatic cycle();
        int  pos;
        bit  applied;
        @(posedge refclk);
        if (reset_n) begin
            if (rel >= 2) begin
                applied = 0;
                for (int c = 0; c < NUM_CH; c++) begin
                    pos       = (m_ph0[c] + m_k[c]) % m_div[c];
                    e_clk[c]  = (pos < m_div[c] / 2);
                    e_tick[c] = (pos == m_div[c] - 1);
                    if (pend && p_ch == c && pos == m_div[c] - 1) begin
                        m_div[c] = p_div;
                        m_ph0[c] = p_ph;
                        m_k[c]   = 0;
                        applied  = 1;
                    end else begin
                        m_k[c]++;
                    end
                end
                if (pend) begin
                    if (applied) pend = 0;
                end else if (DYN && load_reg && int'(load_ch) < NUM_CH) begin
                    pend  = 1;
                    p_ch  = int'(load_ch);
                    p_div = clampd(int'(load_div));
                    p_ph  = clampp(int'(load_phase), p_div);
                end
                lock_age = applied ? 0 : lock_age + 1;
            end
            rel++;
        end
        #1;
    endtask

    task automatic strobe(int ch, int dv, int ph);
        load_ch    = 1'(ch);
        load_div   = CNT_W'(dv);
        load_phase = CNT_W'(ph);
        load_reg   = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if ({clk_out, tick, busy, locked} !== 6'b0) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", {clk_out, tick, busy, locked}, 6'b0);
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
            if (n == 2) begin
                checks++;
                if (tick !== 2'b00) begin
                    errors++;
                    $display("FAIL held_before_release: tick %b required 00", tick);
                end
            end
            if (n == 3) begin
                checks++;
                if (tick !== 2'b11) begin
                    errors++;
                    $display("FAIL first_tick: tick %b required 11", tick);
                end
            end
            if (n == 17 || n == 18) begin
                checks++;
                if (locked !== (n == 18)) begin
                    errors++;
                    $display("FAIL lock_timing edge %0d: locked %b required %b", n, locked, n == 18);
                end
            end
        end
    endtask

    task automatic test_defaults();
        int len;
        len = 200 + $urandom_range(0, 100);
        for (int n = 0; n < len; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL defaults cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
    endtask

    task automatic test_reset_midpend();
        strobe(1, 7, 1);
        cycle();
        load_reg = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({clk_out, tick, busy, locked} !== 6'b0) begin
            errors++;
            $display("FAIL reset_midpend_async: got %b required %b", {clk_out, tick, busy, locked}, 6'b0);
        end
        cycle();
        reset_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL reset_midpend cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
    endtask

    task automatic test_reload();
        repeat ($urandom_range(0, 3)) cycle();
        strobe(0, 6, 0);
        cycle();
        load_reg = 1'b0;
        checks++;
        if (busy !== DYN) begin
            errors++;
            $display("FAIL reload_busy: busy %b required %b", busy, DYN);
        end
        for (int n = 0; n < 60; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL reload cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
    endtask

    task automatic test_clamp();
        strobe(0, 1, 9);
        cycle();
        load_reg = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL clamp cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        strobe(1, 10, 2);
        cycle();
        strobe(1, 3, 0);
        cycle();
        load_reg = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                strobe(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
            end else begin
                load_reg = 1'b0;
            end
            cycle();
            checks++;
            if ({clk_out, tick, busy, locked} !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b required %b", n, {clk_out, tick, busy, locked}, expv());
            end
        end
        load_reg = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reset_midpend();
        test_reload();
        test_clamp();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
